// File: rtl/register_pkg.sv
// register_pkg: shared register-file sizing constants for the MiniMIPS datapath.
package register_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 3;
    localparam int REG_COUNT = 8;
    localparam logic [2:0] ZERO_REG = 3'd0;
endpackage

// File: rtl/register.sv
// register: 8x32 register file, two combinational read ports, one clocked write port.
// Entry 0 is never written, so it reads as zero like MIPS $zero.
module register #(
    parameter int DATA_WIDTH = register_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = register_pkg::ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  RegWrite,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2,
    input  logic                  clock,
    input  logic                  reset
);
    import register_pkg::*;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] W_ZERO = ADDR_WIDTH'(ZERO_REG);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  w_we;
    assign w_we = RegWrite && (write_reg != W_ZERO);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_we) begin
            r_mem[write_reg] <= write_data;
        end
    end
    assign read_data1 = (read_reg1 == W_ZERO) ? '0 : r_mem[read_reg1];
    assign read_data2 = (read_reg2 == W_ZERO) ? '0 : r_mem[read_reg2];
endmodule

// File: tb/tb_register.sv
// tb_register: directed plus random checks of the register file against an array model.
module tb_register;
    import register_pkg::*;
    logic [2:0]  read_reg1, read_reg2, write_reg;
    logic [31:0] write_data, read_data1, read_data2;
    logic        RegWrite, clock, reset;
    logic [31:0] model [REG_COUNT];
    int total = 0;
    int bad = 0;

    register dut (
        .read_reg1(read_reg1), .read_reg2(read_reg2), .write_reg(write_reg),
        .write_data(write_data), .RegWrite(RegWrite), .read_data1(read_data1),
        .read_data2(read_data2), .clock(clock), .reset(reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        return (a == 3'd0) ? 32'h0 : model[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < REG_COUNT; i++) model[i] = 32'h0;
    endtask

    // Applies the write rules to the model at the rising edge, then settles.
    task automatic tick();
        logic we;
        logic [2:0] wa;
        logic [31:0] wd;
        we = RegWrite; wa = write_reg; wd = write_data;
        @(posedge clock);
        if (!reset && we && wa != 3'd0) model[wa] = wd;
        #1;
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < REG_COUNT; a++) begin
            read_reg1 = 3'(a);
            read_reg2 = 3'(REG_COUNT - 1 - a);
            #1;
            chk({tag, "_rd1"}, read_data1, exp_rd(read_reg1));
            chk({tag, "_rd2"}, read_data2, exp_rd(read_reg2));
        end
    endtask

    initial begin
        reset = 1'b1; RegWrite = 1'b0; read_reg1 = '0; read_reg2 = '0;
        write_reg = '0; write_data = '0;
        clear_model();
        #1;
        sweep("reset_initial");
        @(negedge clock);
        reset = 1'b0;
        // basic write/read
        read_reg1 = 3'd1; read_reg2 = 3'd2; write_reg = 3'd1;
        write_data = 32'hFFFF1111; RegWrite = 1'b1;
        tick();
        chk("basic_rd1", read_data1, 32'hFFFF1111);
        chk("basic_rd2", read_data2, 32'h0);
        // hold
        RegWrite = 1'b0; write_reg = 3'd2; write_data = 32'hFFFF0000;
        repeat (3) tick();
        chk("hold_rd1", read_data1, 32'hFFFF1111);
        chk("hold_rd2", read_data2, 32'h0);
        RegWrite = 1'b1;
        tick();
        chk("hold_then_write_rd2", read_data2, 32'hFFFF0000);
        chk("hold_then_write_rd1", read_data1, 32'hFFFF1111);
        // zero register
        write_reg = 3'd0; write_data = 32'hDEADBEEF; read_reg1 = 3'd0; read_reg2 = 3'd0;
        tick();
        chk("zero_rd1", read_data1, 32'h0);
        chk("zero_rd2", read_data2, 32'h0);
        // read during write
        read_reg1 = 3'd5; read_reg2 = 3'd5; write_reg = 3'd5; write_data = 32'h12345678;
        #1;
        chk("rdw_before", read_data1, 32'h0);
        tick();
        chk("rdw_after_rd1", read_data1, 32'h12345678);
        chk("rdw_after_rd2", read_data2, 32'h12345678);
        // random traffic, checking both before and after each edge
        for (int n = 0; n < 300; n++) begin
            read_reg1 = 3'($urandom_range(0, 7));
            read_reg2 = 3'($urandom_range(0, 7));
            write_reg = 3'($urandom_range(0, 7));
            write_data = $urandom;
            RegWrite = 1'($urandom_range(0, 1));
            #1;
            chk("rand_pre_rd1", read_data1, exp_rd(read_reg1));
            chk("rand_pre_rd2", read_data2, exp_rd(read_reg2));
            tick();
            chk("rand_post_rd1", read_data1, exp_rd(read_reg1));
            chk("rand_post_rd2", read_data2, exp_rd(read_reg2));
        end
        // fill 1..7, then async reset mid-cycle with a write pending
        RegWrite = 1'b1;
        for (int a = 1; a < REG_COUNT; a++) begin
            write_reg = 3'(a);
            write_data = $urandom | 32'h1;
            tick();
        end
        RegWrite = 1'b0;
        sweep("filled");
        @(negedge clock);
        #1;
        RegWrite = 1'b1; write_reg = 3'd3; write_data = 32'hCAFEF00D;
        read_reg1 = 3'd3; read_reg2 = 3'd7;
        #1;
        chk("pre_reset_rd1", read_data1, exp_rd(3'd3));
        reset = 1'b1;
        clear_model();
        #1;
        chk("async_reset_rd1", read_data1, 32'h0);
        chk("async_reset_rd2", read_data2, 32'h0);
        tick();
        chk("reset_drops_write", read_data1, 32'h0);
        RegWrite = 1'b0;
        sweep("reset_held");
        @(negedge clock);
        reset = 1'b0;
        #1;
        sweep("after_reset");
        // first write after reset
        read_reg1 = 3'd6; read_reg2 = 3'd3;
        RegWrite = 1'b1; write_reg = 3'd6; write_data = 32'hA5A5_5A5A;
        #1;
        chk("post_reset_pre_edge", read_data1, 32'h0);
        tick();
        chk("post_reset_write_rd1", read_data1, 32'hA5A5_5A5A);
        chk("post_reset_write_rd2", read_data2, 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
